// File: rtl/fanout_bank_sequencer.sv
// Arbitrates two requesters onto one broadcast net, then sweeps one-hot capture enables across the load banks.
// Optional FANOUT_SEQ_ABORT_EN adds i_abort / o_aborted so a sweep can be cut short.
module fanout_bank_sequencer #(
    parameter int NUM_BANKS   = 10,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                         i_clk1,
    input  logic                         i_rst_n,
    input  logic                         i_req0,
    input  logic                         i_req1,
    input  logic                         i_data0,
    input  logic                         i_data1,
`ifdef FANOUT_SEQ_ABORT_EN
    input  logic                         i_abort,
    output logic                         o_aborted,
`endif
    output logic                         o_ack0,
    output logic                         o_ack1,
    output logic                         o_bcast,
    output logic [NUM_BANKS-1:0]         o_bank_en,
    output logic [$clog2(NUM_BANKS)-1:0] o_bank_idx,
    output logic                         o_grant_id,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_bcast;
    logic [NUM_BANKS-1:0] r_bank_en;
    logic [IDX_W-1:0]   r_bank_idx;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_grant_id;
    logic               r_last_grant;
    logic               r_busy;
    logic               r_done;

    logic               w_ack0_next;
    logic               w_ack1_next;
    logic               w_bcast_next;
    logic [NUM_BANKS-1:0] w_bank_en_next;
    logic [IDX_W-1:0]   w_bank_idx_next;
    logic               w_en_valid;
    logic [CNT_W-1:0]   w_hold_next;
    logic               w_grant_next;
    logic               w_last_next;
    logic               w_done_next;
    logic               w_pick;
    logic               w_abort;
    logic               w_abort_hit;

`ifdef FANOUT_SEQ_ABORT_EN
    logic               r_aborted;
    assign w_abort   = i_abort;
    assign o_aborted = r_aborted;
`else
    assign w_abort   = 1'b0;
`endif

    // Round-robin: on a tie the requester that did not win last time is served.
    assign w_pick = (i_req0 && i_req1) ? ~r_last_grant : i_req1;

    always_comb begin
        w_state_next    = r_state;
        w_ack0_next     = 1'b0;
        w_ack1_next     = 1'b0;
        w_bcast_next    = r_bcast;
        w_bank_idx_next = '0;
        w_en_valid      = 1'b0;
        w_hold_next     = '0;
        w_grant_next    = r_grant_id;
        w_last_next     = r_last_grant;
        w_done_next     = 1'b0;
        w_abort_hit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_state_next = S_SETUP;
                    w_ack0_next  = ~w_pick;
                    w_ack1_next  = w_pick;
                    w_bcast_next = w_pick ? i_data1 : i_data0;
                    w_grant_next = w_pick;
                    w_last_next  = w_pick;
                end
            end
            S_SETUP: begin
                if (w_abort) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_abort_hit  = 1'b1;
                end else begin
                    w_state_next = S_SWEEP;
                    w_en_valid   = 1'b1;
                end
            end
            S_SWEEP: begin
                if (w_abort) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_abort_hit  = 1'b1;
                end else if (r_hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    if (r_bank_idx == IDX_W'(NUM_BANKS - 1)) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_bank_idx_next = r_bank_idx + 1'b1;
                        w_en_valid      = 1'b1;
                    end
                end else begin
                    w_hold_next     = r_hold_cnt + 1'b1;
                    w_bank_idx_next = r_bank_idx;
                    w_en_valid      = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Enable decode from the next index keeps bank_en strictly one-hot in SWEEP.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_dec
            assign w_bank_en_next[gi] = w_en_valid && (w_bank_idx_next == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_bcast      <= 1'b0;
            r_bank_en    <= '0;
            r_bank_idx   <= '0;
            r_hold_cnt   <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ack0       <= w_ack0_next;
            r_ack1       <= w_ack1_next;
            r_bcast      <= w_bcast_next;
            r_bank_en    <= w_bank_en_next;
            r_bank_idx   <= w_bank_idx_next;
            r_hold_cnt   <= w_hold_next;
            r_grant_id   <= w_grant_next;
            r_last_grant <= w_last_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= w_done_next;
        end
    end

`ifdef FANOUT_SEQ_ABORT_EN
    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort_hit;
`endif

    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_bcast    = r_bcast;
    assign o_bank_en  = r_bank_en;
    assign o_bank_idx = r_bank_idx;
    assign o_grant_id = r_grant_id;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
